bcd_display_scanner: RTL and testbench
======================================

Name: bcd_display_scanner

Overview:
- Consumes the BCD time fields and field-select code produced by the countdown commander and drives a 6-digit, multiplexed, common-anode 7-segment display.
- While presetting, the currently selected field blinks; while the countdown runs, nothing blinks; after time-out, the whole display flashes.
- Sits between the commander/countdown path and the board's seven-segment pins.

Parameters:
- SCAN_DIV, 100000: clk_core cycles per digit slot; must be ≥ 2.
- BLINK_DIV, 25000000: clk_core cycles per blink half-period; must be ≥ 2.

Ports:
- clk_core  input  1  core clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- min_i  input  8  BCD minutes, [7:4] tens, [3:0] units.
- sec_i  input  8  BCD seconds.
- ms_10_i  input  8  BCD hundredths of a second.
- target_i  input  2  field select: 00 = ms_10, 01 = sec, 10 = min, 11 = running (no field blinks).
- time_out_i  input  1  countdown expired; level signal.
- an_o  output  6  digit enables, active-low, one-hot-low.
- seg_o  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_o  output  1  decimal point, active-low.

Behaviour:
- Reset values:
  - an_o = 6'b111111, seg_o = 7'b1111111, dp_o = 1.
  - Digit index idx = 0, scan counter = 0, blink counter = 0, blink_vis = 1.
  - Snapshot = 0, load_pending = 1.
- Scan counter:
  - Counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted for exactly one cycle when the count equals SCAN_DIV-1.
  - On tick, idx advances 0→1→…→5→0.
- Snapshot (prevents tearing within a frame):
  - min/sec/ms_10/target/time_out are captured into internal registers when (tick and idx == 5), or on the first clock edge after reset release (load_pending, which then clears).
  - Input changes between snapshots are invisible on the display.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and wraps.
  - blink_vis toggles at each wrap.
  - It runs freely and is not reset by target or time_out changes.
- Digit mapping:
  - idx0 = ms_10 units, idx1 = ms_10 tens, idx2 = sec units, idx3 = sec tens, idx4 = min units, idx5 = min tens.
  - an_o[idx] = 0 and all other an_o bits = 1.
- Decimal point: dp_o = 0 when idx is 2 or 4 (renders MM.SS.hh); otherwise 1.
- Segment decode:
  - Nibble 0–9 gives standard digits, e.g. 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - Nibble A–F (invalid BCD) gives a dash, 7'b0111111.
- Blanking (seg_o = 7'b1111111; dp_o forced to 1; an_o still driven normally):
  - Applies when blink_vis = 0 and the snapshot has time_out = 1 (all digits), or
  - when blink_vis = 0, snapshot target != 11, and the digit belongs to the selected field.
  - time_out takes priority over field blinking.
- Output registration:
  - an_o, seg_o and dp_o are registered.
  - They reflect idx, the snapshot and blink_vis from the previous cycle, so latency is 1 cycle after any idx or blink_vis change.
- Reset behaviour:
  - Asserting rst mid-frame immediately (asynchronously) drives outputs to their reset values.
  - After release, scanning restarts at idx0 using a fresh snapshot.
- No leading-zero suppression.

Decomposition:
- Package seg7_pkg:
  - Target codes TGT_MS10 / TGT_SEC / TGT_MIN / TGT_RUN.
  - SEG_BLANK = 7'h7F and SEG_DASH = 7'h3F.
  - The digit-to-field mapping constants.
- Sub-module bcd_to_seg7: combinational 4-bit nibble → 7-bit active-low segment decoder.
  - Used once in this block.
  - Reusable by other display paths.

Test Plan:
- Bench parameters for all scenarios: SCAN_DIV = 4, BLINK_DIV = 64.
1. Reset, then release with min=0x10, sec=0x00, ms_10=0x00, target=11 → an_o walks 111110, 111101, …, 011111, each held 4 cycles. seg_o on idx5 = 7'b1111001 and on idx4 = 7'b1000000. dp_o = 0 only on idx2 and idx4.
2. target=01, sec=0x59 → while blink_vis=0, idx2/idx3 show seg_o = 7'h7F; while blink_vis=1, idx3 = '5' (7'b0010010) and idx2 = '9' (7'b0010000). Other digits are never blanked.
3. Change ms_10 from 0x00 to 0x42 while idx=1 → the change does not appear until idx wraps through 5→0; idx0 then shows '2' (7'b0100100) and idx1 shows '4' (7'b0011001).
4. time_out_i=1 with target=00 → all six digits are blank during blink_vis=0 and all are visible during blink_vis=1.
5. ms_10=0x0C → idx0 shows a dash (7'h3F).
6. Assert rst while idx=3 → an_o=111111 and seg_o=7'h7F in the same cycle, before any clock edge. After release, an_o=111110 on the first registered output.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared constants, types and helpers for the 7-segment display
//            path: field-select codes, special segment patterns, the
//            digit-slot to time-field mapping and the snapshot record.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Field-select codes coming from the countdown commander.
    localparam logic [1:0] TGT_MS10 = 2'b00;
    localparam logic [1:0] TGT_SEC  = 2'b01;
    localparam logic [1:0] TGT_MIN  = 2'b10;
    localparam logic [1:0] TGT_RUN  = 2'b11;

    // Active-low segment patterns {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Digit slots, rightmost first: hh units/tens, SS units/tens, MM units/tens.
    localparam int         NUM_DIGITS  = 6;
    localparam logic [2:0] DIG_MS10_U  = 3'd0;
    localparam logic [2:0] DIG_MS10_T  = 3'd1;
    localparam logic [2:0] DIG_SEC_U   = 3'd2;
    localparam logic [2:0] DIG_SEC_T   = 3'd3;
    localparam logic [2:0] DIG_MIN_U   = 3'd4;
    localparam logic [2:0] DIG_MIN_T   = 3'd5;

    // Frame-coherent copy of everything the display shows.
    typedef struct packed {
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] ms_10;
        logic [1:0] target;
        logic       time_out;
    } snap_t;

    // Time field owning a digit slot; unused slot codes map to TGT_RUN so
    // they can never match a selected field.
    function automatic logic [1:0] digit_field(input logic [2:0] idx);
        case (idx)
            DIG_MS10_U, DIG_MS10_T: digit_field = TGT_MS10;
            DIG_SEC_U,  DIG_SEC_T:  digit_field = TGT_SEC;
            DIG_MIN_U,  DIG_MIN_T:  digit_field = TGT_MIN;
            default:                digit_field = TGT_RUN;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg7.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bcd_to_seg7
// Purpose  : Combinational BCD nibble to active-low 7-segment decoder.
//            Non-BCD codes (A-F) render as a dash so corrupt data is visible.
// Ports    : bcd_i [3:0]  BCD digit
//            seg_o [6:0]  segments {g,f,e,d,c,b,a}, active-low
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0: seg_o = 7'b1000000;
            4'd1: seg_o = 7'b1111001;
            4'd2: seg_o = 7'b0100100;
            4'd3: seg_o = 7'b0110000;
            4'd4: seg_o = 7'b0011001;
            4'd5: seg_o = 7'b0010010;
            4'd6: seg_o = 7'b0000010;
            4'd7: seg_o = 7'b1111000;
            4'd8: seg_o = 7'b0000000;
            4'd9: seg_o = 7'b0010000;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/bcd_display_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : bcd_display_scanner
// Purpose  : Drives a 6-digit multiplexed common-anode 7-segment display
//            (MM.SS.hh) from BCD time fields. The selected field blinks while
//            presetting; the whole display flashes after time-out.
// Ports    : clk_core          core clock, rising edge
//            rst               asynchronous active-high reset
//            min_i/sec_i/ms_10_i [7:0]  BCD fields, [7:4] tens, [3:0] units
//            target_i [1:0]    field select (11 = running, nothing blinks)
//            time_out_i        countdown expired (level)
//            an_o [5:0]        digit enables, active-low one-hot
//            seg_o [6:0]       segments {g,f,e,d,c,b,a}, active-low
//            dp_o              decimal point, active-low
// Revision : 1.0 - initial release
// ============================================================================
module bcd_display_scanner
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk_core,
    input  logic       rst,
    input  logic [7:0] min_i,
    input  logic [7:0] sec_i,
    input  logic [7:0] ms_10_i,
    input  logic [1:0] target_i,
    input  logic       time_out_i,
    output logic [5:0] an_o,
    output logic [6:0] seg_o,
    output logic       dp_o
);

    localparam int              SCAN_W     = $clog2(SCAN_DIV);
    localparam int              BLINK_W    = $clog2(BLINK_DIV);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    logic [SCAN_W-1:0]  scan_cnt_q,  scan_cnt_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [2:0]         idx_q,       idx_d;
    logic               blink_vis_q, blink_vis_d;
    logic               load_pending_q, load_pending_d;
    snap_t              snap_q,      snap_d;
    logic [5:0]         an_q,        an_d;
    logic [6:0]         seg_q,       seg_d;
    logic               dp_q,        dp_d;

    logic               tick;
    logic               blink_wrap;
    logic               blank;
    logic [3:0]         nibble;
    logic [6:0]         dec_seg;

    // ------------------------------------------------------------------
    // Scan / blink timing and frame snapshot
    // ------------------------------------------------------------------
    always_comb begin
        tick        = (scan_cnt_q == SCAN_LAST);
        scan_cnt_d  = tick ? '0 : scan_cnt_q + 1'b1;

        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == DIG_MIN_T) ? DIG_MS10_U : idx_q + 3'd1;
        end

        blink_wrap  = (blink_cnt_q == BLINK_LAST);
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_vis_d = blink_wrap ? ~blink_vis_q : blink_vis_q;

        // Snapshot only at the end of a full frame so a value never tears
        // across digits; the first edge after reset loads immediately.
        snap_d         = snap_q;
        load_pending_d = 1'b0;
        if (load_pending_q || (tick && idx_q == DIG_MIN_T)) begin
            snap_d.min      = min_i;
            snap_d.sec      = sec_i;
            snap_d.ms_10    = ms_10_i;
            snap_d.target   = target_i;
            snap_d.time_out = time_out_i;
        end
    end

    // ------------------------------------------------------------------
    // Digit selection, decode and blanking
    // ------------------------------------------------------------------
    always_comb begin
        case (idx_q)
            DIG_MS10_U: nibble = snap_q.ms_10[3:0];
            DIG_MS10_T: nibble = snap_q.ms_10[7:4];
            DIG_SEC_U:  nibble = snap_q.sec[3:0];
            DIG_SEC_T:  nibble = snap_q.sec[7:4];
            DIG_MIN_U:  nibble = snap_q.min[3:0];
            DIG_MIN_T:  nibble = snap_q.min[7:4];
            default:    nibble = 4'hF;
        endcase
    end

    bcd_to_seg7 u_dec (
        .bcd_i (nibble),
        .seg_o (dec_seg)
    );

    always_comb begin
        // Time-out flashes everything; otherwise only the selected field
        // blinks, and TGT_RUN never matches a digit's field.
        blank = ~blink_vis_q &
                (snap_q.time_out |
                 ((snap_q.target != TGT_RUN) && (digit_field(idx_q) == snap_q.target)));

        an_d  = ~(6'b000001 << idx_q);
        seg_d = blank ? SEG_BLANK : dec_seg;
        dp_d  = blank ? 1'b1 : ~((idx_q == DIG_SEC_U) || (idx_q == DIG_MIN_U));
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            scan_cnt_q     <= '0;
            blink_cnt_q    <= '0;
            idx_q          <= DIG_MS10_U;
            blink_vis_q    <= 1'b1;
            load_pending_q <= 1'b1;
            snap_q         <= '0;
            an_q           <= 6'b111111;
            seg_q          <= SEG_BLANK;
            dp_q           <= 1'b1;
        end else begin
            scan_cnt_q     <= scan_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            idx_q          <= idx_d;
            blink_vis_q    <= blink_vis_d;
            load_pending_q <= load_pending_d;
            snap_q         <= snap_d;
            an_q           <= an_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end

    assign an_o  = an_q;
    assign seg_o = seg_q;
    assign dp_o  = dp_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_scanner.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_bcd_display_scanner
// Purpose  : Directed, table-driven bench for bcd_display_scanner with
//            SCAN_DIV = 4 and BLINK_DIV = 64. Cycle k counts rising edges
//            after reset release; the output seen after edge k shows digit
//            slot ((k-1)/4) mod 6 with blink phase ((k-1)/64) odd = dark.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_display_scanner;

    logic       clk_core = 1'b0;
    logic       rst      = 1'b1;
    logic [7:0] min_i    = 8'h00;
    logic [7:0] sec_i    = 8'h00;
    logic [7:0] ms_10_i  = 8'h00;
    logic [1:0] target_i = 2'b11;
    logic       time_out_i = 1'b0;
    logic [5:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;

    bcd_display_scanner #(
        .SCAN_DIV  (4),
        .BLINK_DIV (64)
    ) dut (
        .clk_core   (clk_core),
        .rst        (rst),
        .min_i      (min_i),
        .sec_i      (sec_i),
        .ms_10_i    (ms_10_i),
        .target_i   (target_i),
        .time_out_i (time_out_i),
        .an_o       (an_o),
        .seg_o      (seg_o),
        .dp_o       (dp_o)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic       do_rst;
        logic [7:0] mn;
        logic [7:0] sc;
        logic [7:0] ms;
        logic [1:0] tg;
        logic       to;
        int         k;
        logic [5:0] an;
        logic [6:0] seg;
        logic       dp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    function automatic vec_t mk(input logic r, input logic [7:0] mn, input logic [7:0] sc,
                                input logic [7:0] ms, input logic [1:0] tg, input logic to,
                                input int k, input logic [5:0] an, input logic [6:0] seg,
                                input logic dp, input string name);
        vec_t v;
        v.do_rst = r;  v.mn = mn;  v.sc = sc;  v.ms = ms;  v.tg = tg;  v.to = to;
        v.k = k;  v.an = an;  v.seg = seg;  v.dp = dp;  v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [5:0] an, input logic [6:0] seg,
                         input logic dp);
        vectors++;
        if (an_o !== an || seg_o !== seg || dp_o !== dp) begin
            miscompares++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                     name, an_o, seg_o, dp_o, an, seg, dp);
        end
    endtask

    task automatic drive(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms,
                         input logic [1:0] tg, input logic to);
        min_i = mn;  sec_i = sc;  ms_10_i = ms;  target_i = tg;  time_out_i = to;
    endtask

    task automatic do_reset(input logic [7:0] mn, input logic [7:0] sc, input logic [7:0] ms,
                            input logic [1:0] tg, input logic to);
        @(negedge clk_core);
        rst = 1'b1;
        drive(mn, sc, ms, tg, to);
        repeat (2) @(negedge clk_core);
        rst = 1'b0;
        cyc = 0;
    endtask

    // Run until the output after rising edge `k` is settled (next falling edge).
    task automatic advance(input int k, input string name);
        if (k <= cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: table cycle %0d not after current cycle %0d", name, k, cyc);
        end
        while (cyc < k) begin
            @(posedge clk_core);
            cyc++;
        end
        @(negedge clk_core);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // --- A: basic scan walk, running mode (no blink) ---
        vecs.push_back(mk(1, 8'h10, 8'h00, 8'h00, 2'b11, 0,  1, 6'b111110, 7'b1000000, 1, "A_idx0"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0,  4, 6'b111110, 7'b1000000, 1, "A_idx0_hold"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0,  5, 6'b111101, 7'b1000000, 1, "A_idx1"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0,  9, 6'b111011, 7'b1000000, 0, "A_idx2_dp"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0, 13, 6'b110111, 7'b1000000, 1, "A_idx3"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0, 17, 6'b101111, 7'b1000000, 0, "A_idx4_dp"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0, 21, 6'b011111, 7'b1111001, 1, "A_idx5"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0, 25, 6'b111110, 7'b1000000, 1, "A_wrap"));
        vecs.push_back(mk(0, 8'h10, 8'h00, 8'h00, 2'b11, 0, 70, 6'b011111, 7'b1111001, 1, "A_run_no_blink"));
        // --- B: seconds field blinks ---
        vecs.push_back(mk(1, 8'h00, 8'h59, 8'h00, 2'b01, 0,   9, 6'b111011, 7'b0010000, 0, "B_sec_u_vis"));
        vecs.push_back(mk(0, 8'h00, 8'h59, 8'h00, 2'b01, 0,  13, 6'b110111, 7'b0010010, 1, "B_sec_t_vis"));
        vecs.push_back(mk(0, 8'h00, 8'h59, 8'h00, 2'b01, 0,  77, 6'b111101, 7'b1000000, 1, "B_ms_t_unsel"));
        vecs.push_back(mk(0, 8'h00, 8'h59, 8'h00, 2'b01, 0,  81, 6'b111011, 7'b1111111, 1, "B_sec_u_blank"));
        vecs.push_back(mk(0, 8'h00, 8'h59, 8'h00, 2'b01, 0,  85, 6'b110111, 7'b1111111, 1, "B_sec_t_blank"));
        vecs.push_back(mk(0, 8'h00, 8'h59, 8'h00, 2'b01, 0,  89, 6'b101111, 7'b1000000, 0, "B_min_u_unsel"));
        vecs.push_back(mk(0, 8'h00, 8'h59, 8'h00, 2'b01, 0, 129, 6'b111011, 7'b0010000, 0, "B_sec_u_back"));
        // --- C: mid-frame input change held off until frame wrap ---
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, 2'b11, 0,  5, 6'b111101, 7'b1000000, 1, "C_before"));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h42, 2'b11, 0,  8, 6'b111101, 7'b1000000, 1, "C_hidden"));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h42, 2'b11, 0, 25, 6'b111110, 7'b0100100, 1, "C_ms_u_new"));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h42, 2'b11, 0, 29, 6'b111101, 7'b0011001, 1, "C_ms_t_new"));
        // --- D: time-out flashes all digits ---
        vecs.push_back(mk(1, 8'h12, 8'h34, 8'h56, 2'b00, 1,   4, 6'b111110, 7'b0000010, 1, "D_vis0"));
        vecs.push_back(mk(0, 8'h12, 8'h34, 8'h56, 2'b00, 1,  21, 6'b011111, 7'b1111001, 1, "D_vis5"));
        vecs.push_back(mk(0, 8'h12, 8'h34, 8'h56, 2'b00, 1,  65, 6'b101111, 7'b1111111, 1, "D_dark4"));
        vecs.push_back(mk(0, 8'h12, 8'h34, 8'h56, 2'b00, 1,  69, 6'b011111, 7'b1111111, 1, "D_dark5"));
        vecs.push_back(mk(0, 8'h12, 8'h34, 8'h56, 2'b00, 1,  73, 6'b111110, 7'b1111111, 1, "D_dark0"));
        vecs.push_back(mk(0, 8'h12, 8'h34, 8'h56, 2'b00, 1,  81, 6'b111011, 7'b1111111, 1, "D_dark2_dp"));
        vecs.push_back(mk(0, 8'h12, 8'h34, 8'h56, 2'b00, 1, 129, 6'b111011, 7'b0011001, 0, "D_back2"));
        // --- E: invalid BCD dashes, minutes field blinks ---
        vecs.push_back(mk(1, 8'hE7, 8'h76, 8'h0C, 2'b10, 0,  4, 6'b111110, 7'b0111111, 1, "E_dash_ms_u"));
        vecs.push_back(mk(0, 8'hE7, 8'h76, 8'h0C, 2'b10, 0,  5, 6'b111101, 7'b1000000, 1, "E_ms_t"));
        vecs.push_back(mk(0, 8'hE7, 8'h76, 8'h0C, 2'b10, 0, 17, 6'b101111, 7'b1111000, 0, "E_min_u"));
        vecs.push_back(mk(0, 8'hE7, 8'h76, 8'h0C, 2'b10, 0, 21, 6'b011111, 7'b0111111, 1, "E_dash_min_t"));
        vecs.push_back(mk(0, 8'hE7, 8'h76, 8'h0C, 2'b10, 0, 65, 6'b101111, 7'b1111111, 1, "E_min_u_blank"));
        vecs.push_back(mk(0, 8'hE7, 8'h76, 8'h0C, 2'b10, 0, 69, 6'b011111, 7'b1111111, 1, "E_min_t_blank"));
        vecs.push_back(mk(0, 8'hE7, 8'h76, 8'h0C, 2'b10, 0, 73, 6'b111110, 7'b0111111, 1, "E_ms_unsel"));
        vecs.push_back(mk(0, 8'hE7, 8'h76, 8'h0C, 2'b10, 0, 81, 6'b111011, 7'b0000010, 0, "E_sec_unsel"));
        // --- F: hundredths field blinks ---
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h38, 2'b00, 0,  4, 6'b111110, 7'b0000000, 1, "F_ms_u"));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h38, 2'b00, 0,  5, 6'b111101, 7'b0110000, 1, "F_ms_t"));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h38, 2'b00, 0, 65, 6'b101111, 7'b1000000, 0, "F_min_unsel"));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h38, 2'b00, 0, 73, 6'b111110, 7'b1111111, 1, "F_ms_u_blank"));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h38, 2'b00, 0, 77, 6'b111101, 7'b1111111, 1, "F_ms_t_blank"));

        // Reset state while held in reset across a clock edge.
        rst = 1'b1;
        repeat (2) @(negedge clk_core);
        check("reset_state", 6'b111111, 7'b1111111, 1'b1);

        foreach (vecs[i]) begin
            if (vecs[i].do_rst)
                do_reset(vecs[i].mn, vecs[i].sc, vecs[i].ms, vecs[i].tg, vecs[i].to);
            else
                drive(vecs[i].mn, vecs[i].sc, vecs[i].ms, vecs[i].tg, vecs[i].to);
            advance(vecs[i].k, vecs[i].name);
            check(vecs[i].name, vecs[i].an, vecs[i].seg, vecs[i].dp);
        end

        // Asynchronous reset mid-frame, then restart with a fresh snapshot.
        do_reset(8'h00, 8'h00, 8'h00, 2'b11, 1'b0);
        advance(13, "R_pre");
        check("R_pre_idx3", 6'b110111, 7'b1000000, 1'b1);
        #2;
        rst     = 1'b1;
        ms_10_i = 8'h07;
        #1;
        check("R_async", 6'b111111, 7'b1111111, 1'b1);
        @(negedge clk_core);
        rst = 1'b0;
        cyc = 0;
        advance(1, "R_first");
        check("R_first_idx0", 6'b111110, 7'b1000000, 1'b1);
        advance(2, "R_fresh");
        check("R_fresh_snap", 6'b111110, 7'b1111000, 1'b1);
        advance(5, "R_idx1");
        check("R_idx1", 6'b111101, 7'b1000000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
